// File: rtl/restoring_divider_if.sv
// Start/done request and result bundle for restoring_divider.
// master = the issuing pipeline, slave = the divider.
interface restoring_divider_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock; done N cycles after acceptance (1 for divide-by-zero).
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient, remainder follows dividend sign).
module restoring_divider #(
  parameter int N = 8
) (
  input logic            clk,
  input logic            rst,
  restoring_divider_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   ONE_N1 = {{N{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   r_q, q_q, d_q;
  logic [CW-1:0]  cnt;
  logic           accept, last;
  logic [N:0]     r_shift, trial;
  logic [N-1:0]   r_next, q_next;
  logic [N-1:0]   a_mag, d_mag, res_q, res_r;

  assign accept = bus.start && (state != CALC);
  assign last   = (cnt == CW'(N-1));

  // One trial subtraction per clock; restore when the result goes negative.
  always_comb begin
    r_shift = {r_q, q_q[N-1]};
    trial   = r_shift + {1'b1, ~d_q} + ONE_N1;
    q_next  = {q_q[N-2:0], ~trial[N]};
    r_next  = trial[N] ? r_shift[N-1:0] : trial[N-1:0];
  end

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  always_comb begin
    a_mag = bus.dividend[N-1] ? (~bus.dividend + ONE_N) : bus.dividend;
    d_mag = bus.divisor[N-1]  ? (~bus.divisor  + ONE_N) : bus.divisor;
    res_q = neg_q ? (~q_next + ONE_N) : q_next;
    res_r = neg_r ? (~r_next + ONE_N) : r_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
      neg_r <= bus.dividend[N-1];
    end
  end
`else
  always_comb begin
    a_mag = bus.dividend;
    d_mag = bus.divisor;
    res_q = q_next;
    res_r = r_next;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : CALC;
        else           state_nxt = IDLE;
      end
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      CALC:    bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Result registers only move on the edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q             <= '0;
      q_q             <= '0;
      d_q             <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else if (accept) begin
      r_q <= '0;
      q_q <= a_mag;
      d_q <= d_mag;
      cnt <= '0;
      if (bus.divisor == '0) begin
        bus.quotient    <= '1;
        bus.remainder   <= bus.dividend;
        bus.div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      r_q <= r_next;
      q_q <= q_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        bus.quotient    <= res_q;
        bus.remainder   <= res_r;
        bus.div_by_zero <= 1'b0;
      end
    end
  end
endmodule
